// File: rtl/crossover_stage_pkg.sv
// Shared definitions for the GA crossover stage: LFSR taps, FSM state
// encoding and a constant clog2 helper for sizing the cut register.
package crossover_stage_pkg;

    // Galois feedback taps for the 16-bit right-shifting LFSR (maximal length)
    localparam logic [15:0] GA_LFSR_TAPS = 16'hB400;

    // Crossover FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        GA_XO_IDLE   = 2'd0,
        GA_XO_PICK   = 2'd1,
        GA_XO_MUTATE = 2'd2,
        GA_XO_DONE   = 2'd3
    } xo_state_e;

    // Ceiling log2 for elaboration-time sizing; bounded loop keeps it synthesizable
    function automatic int ga_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/crossover_stage_lfsr16.sv
// Free-running 16-bit Galois LFSR, shifting right every cycle.
// A zero seed would lock the register at zero, so it is replaced by 1.
module lfsr16
    import crossover_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    // Reload the seed on reset, otherwise advance one Galois step
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else begin
            q <= (q >> 1) ^ (q[0] ? GA_LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/crossover_stage.sv
// One child chromosome per request: single-point crossover of two latched
// parents at a random cut, then an optional single-bit flip at the cut.
// child/child_valid feed the population buffer's D/ce directly.
//
// Request handshake: start is only looked at while busy=0 (IDLE). The edge
// that sees start=1 in IDLE accepts the request and latches both parents;
// busy is high from the next cycle through the DONE cycle, and child_valid
// pulses for exactly the DONE cycle. Starts seen while busy are dropped.
module crossover_stage
    import crossover_stage_pkg::*;
#(
    parameter int          Width   = 8,
    parameter logic [15:0] Seed    = 16'h0001,
    parameter int          MutRate = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [Width-1:0] parent_a,
    input  logic [Width-1:0] parent_b,
    output logic             busy,
    output logic [Width-1:0] child,
    output logic             child_valid
);

    localparam int          CutBits   = ga_clog2(Width);
    localparam logic [31:0] WIDTH_U   = 32'(Width);
    localparam logic [8:0]  MUT_RATE9 = 9'(MutRate);

    xo_state_e          state;
    xo_state_e          state_next;
    logic [15:0]        lfsr;
    logic [7:0]         unused_lfsr_hi;
    logic [Width-1:0]   pa;
    logic [Width-1:0]   pb;
    logic [Width-1:0]   mix;
    logic [Width-1:0]   flip;
    logic [CutBits-1:0] cut;
    logic [CutBits-1:0] cand;
    logic               cand_ok;
    logic               mutate_hit;
    logic               latch_en;
    logic               cut_en;
    logic               child_en;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (Seed),
        .q    (lfsr)
    );

    // Only the low byte drives cut and mutation decisions
    assign unused_lfsr_hi = lfsr[15:8];

    // Rejection sampling: candidates >= Width are discarded and redrawn next cycle
    assign cand       = lfsr[CutBits-1:0];
    assign cand_ok    = (32'(cand) < WIDTH_U);
    assign mutate_hit = ({1'b0, lfsr[7:0]} < MUT_RATE9);

    assign busy        = (state != GA_XO_IDLE);
    assign child_valid = (state == GA_XO_DONE);

    // Crossover mix: bits below the cut come from A, the rest from B
    always_comb begin
        mix = pb;
        for (int i = 0; i < Width; i++) begin
            if (i < int'(cut)) begin
                mix[i] = pa[i];
            end
        end
    end

    // Mutation mask: the single bit at the cut position
    assign flip = {{(Width-1){1'b0}}, 1'b1} << cut;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= GA_XO_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath load enables
    always_comb begin
        state_next = state;
        latch_en   = 1'b0;
        cut_en     = 1'b0;
        child_en   = 1'b0;
        case (state)
            GA_XO_IDLE: begin
                if (start) begin
                    latch_en   = 1'b1;
                    state_next = GA_XO_PICK;
                end
            end
            GA_XO_PICK: begin
                if (cand_ok) begin
                    cut_en     = 1'b1;
                    state_next = GA_XO_MUTATE;
                end
            end
            GA_XO_MUTATE: begin
                child_en   = 1'b1;
                state_next = GA_XO_DONE;
            end
            GA_XO_DONE: begin
                state_next = GA_XO_IDLE;
            end
            default: begin
                state_next = GA_XO_IDLE;
            end
        endcase
    end

    // Parent latches, cut register and child register; child holds between DONEs
    always_ff @(posedge clk) begin
        if (rst) begin
            pa    <= '0;
            pb    <= '0;
            cut   <= '0;
            child <= '0;
        end else begin
            if (latch_en) begin
                pa <= parent_a;
                pb <= parent_b;
            end
            if (cut_en) begin
                cut <= cand;
            end
            if (child_en) begin
                child <= mutate_hit ? (mix ^ flip) : mix;
            end
        end
    end

endmodule

// File: tb/tb_crossover_stage.sv
// Bench for crossover_stage: several parameterisations side by side, driven
// by one directed sequence with random parents, checked against a model
// that derives cut, mutation and latency from the LFSR sequence.
module tb_crossover_stage;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Stimulus groups: 0 W8/rate0, 1 W8/rate256, 2 W6/rate100,
    // 3 seed 1234 (two twins), 4 seed 1 vs seed 0 (twins)
    logic       st [5];
    logic [7:0] pa [5];
    logic [7:0] pb [5];

    logic       busy0, busy1, busy2, busy3, busy4, busy5, busy6;
    logic       cv0, cv1, cv2, cv3, cv4, cv5, cv6;
    logic [7:0] ch0, ch1, ch3, ch4, ch5, ch6;
    logic [5:0] ch2;

    crossover_stage #(.Width(8), .Seed(16'h0001), .MutRate(0)) u0 (
        .clk(clk), .rst(rst), .start(st[0]), .parent_a(pa[0]), .parent_b(pb[0]),
        .busy(busy0), .child(ch0), .child_valid(cv0));
    crossover_stage #(.Width(8), .Seed(16'h0001), .MutRate(256)) u1 (
        .clk(clk), .rst(rst), .start(st[1]), .parent_a(pa[1]), .parent_b(pb[1]),
        .busy(busy1), .child(ch1), .child_valid(cv1));
    crossover_stage #(.Width(6), .Seed(16'h0001), .MutRate(100)) u2 (
        .clk(clk), .rst(rst), .start(st[2]), .parent_a(pa[2][5:0]), .parent_b(pb[2][5:0]),
        .busy(busy2), .child(ch2), .child_valid(cv2));
    crossover_stage #(.Width(8), .Seed(16'h1234), .MutRate(128)) u3 (
        .clk(clk), .rst(rst), .start(st[3]), .parent_a(pa[3]), .parent_b(pb[3]),
        .busy(busy3), .child(ch3), .child_valid(cv3));
    crossover_stage #(.Width(8), .Seed(16'h1234), .MutRate(128)) u4 (
        .clk(clk), .rst(rst), .start(st[3]), .parent_a(pa[3]), .parent_b(pb[3]),
        .busy(busy4), .child(ch4), .child_valid(cv4));
    crossover_stage #(.Width(8), .Seed(16'h0001), .MutRate(128)) u5 (
        .clk(clk), .rst(rst), .start(st[4]), .parent_a(pa[4]), .parent_b(pb[4]),
        .busy(busy5), .child(ch5), .child_valid(cv5));
    crossover_stage #(.Width(8), .Seed(16'h0000), .MutRate(128)) u6 (
        .clk(clk), .rst(rst), .start(st[4]), .parent_a(pa[4]), .parent_b(pb[4]),
        .busy(busy6), .child(ch6), .child_valid(cv6));

    // Per-group model parameters
    int          g_width [5] = '{8, 8, 6, 8, 8};
    int          g_rate  [5] = '{0, 256, 100, 128, 128};
    logic [15:0] g_seed  [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h1234, 16'h0000};
    int          g_prim  [5] = '{0, 1, 2, 3, 5};
    int          g_twin  [5] = '{-1, -1, -1, 4, 6};

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    function automatic logic [15:0] lstep(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    // LFSR value each group's DUT holds in the current cycle
    logic [15:0] m_lfsr [5];
    always @(posedge clk) begin
        for (int g = 0; g < 5; g++) begin
            m_lfsr[g] <= rst ? seed_fix(g_seed[g]) : lstep(m_lfsr[g]);
        end
    end

    // From the LFSR value in the accepting cycle: draw cuts (low 3 bits, since
    // clog2 of 6 and 8 are both 3) until one is < width, mutate on the next value.
    function automatic void predict(input int g, input logic [15:0] l0,
                                    input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] child, output int lat,
                                    output int cut);
        logic [15:0] x;
        logic [7:0]  mix;
        int          draws;
        x = lstep(l0);
        draws = 1;
        while (int'(x & 16'h0007) >= g_width[g]) begin
            x = lstep(x);
            draws++;
        end
        cut = int'(x & 16'h0007);
        mix = 8'h00;
        for (int i = 0; i < g_width[g]; i++) begin
            mix[i] = (i < cut) ? a[i] : b[i];
        end
        x = lstep(x);
        if (int'(x[7:0]) < g_rate[g]) begin
            mix[cut] = ~mix[cut];
        end
        child = mix;
        lat = draws + 2;
    endfunction

    // ---------------- DUT accessors ----------------
    function automatic logic [7:0] child_of(input int i);
        case (i)
            0: return ch0;
            1: return ch1;
            2: return {2'b00, ch2};
            3: return ch3;
            4: return ch4;
            5: return ch5;
            default: return ch6;
        endcase
    endfunction

    function automatic logic cv_of(input int i);
        case (i)
            0: return cv0;
            1: return cv1;
            2: return cv2;
            3: return cv3;
            4: return cv4;
            5: return cv5;
            default: return cv6;
        endcase
    endfunction

    function automatic logic busy_of(input int i);
        case (i)
            0: return busy0;
            1: return busy1;
            2: return busy2;
            3: return busy3;
            4: return busy4;
            5: return busy5;
            default: return busy6;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request on group g; returns the DUT child, observed latency and model cut
    task automatic run_req(input int g, input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] got, output int lat, output int cut);
        logic [15:0] l0;
        logic [7:0]  exp_c;
        int          exp_lat;
        int          p;
        logic        seen;
        p = g_prim[g];
        @(negedge clk);
        st[g] = 1'b1;
        pa[g] = a;
        pb[g] = b;
        l0 = m_lfsr[g];
        @(posedge clk);
        #1;
        st[g] = 1'b0;
        pa[g] = ~a;
        pb[g] = ~b;
        predict(g, l0, a, b, exp_c, exp_lat, cut);
        check("busy_after_accept", 32'(busy_of(p)), 32'd1);
        lat = 1;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(posedge clk);
            #1;
            lat++;
            if (cv_of(p)) seen = 1'b1;
        end
        check("valid_within_bound", 32'(seen), 32'd1);
        got = child_of(p);
        check("child", 32'(got), 32'(exp_c));
        check("latency", 32'(lat), 32'(exp_lat));
        check("busy_in_done", 32'(busy_of(p)), 32'd1);
        if (g_twin[g] >= 0) begin
            check("twin_valid", 32'(cv_of(g_twin[g])), 32'd1);
            check("twin_child", 32'(child_of(g_twin[g])), 32'(exp_c));
        end
        @(posedge clk);
        #1;
        check("single_pulse", 32'(cv_of(p)), 32'd0);
        check("idle_after_done", 32'(busy_of(p)), 32'd0);
        check("child_held", 32'(child_of(p)), 32'(exp_c));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] got;
        logic [7:0] a;
        logic [7:0] b;
        int         lat;
        int         cut;
        int         pulses;
        int         last;
        int         stale;
        bit         cut_seen [8];

        rst = 1'b1;
        for (int g = 0; g < 5; g++) begin
            st[g] = 1'b0;
            pa[g] = 8'h00;
            pb[g] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        // Reset state on every instance
        for (int i = 0; i < 7; i++) begin
            check("reset_busy", 32'(busy_of(i)), 32'd0);
            check("reset_valid", 32'(cv_of(i)), 32'd0);
            check("reset_child", 32'(child_of(i)), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // 1: all-ones A over all-zeros B gives a low-ones mask, latency 3
        run_req(0, 8'hFF, 8'h00, got, lat, cut);
        check("t1_latency3", 32'(lat), 32'd3);
        check("t1_mask_shape", 32'((((got + 8'd1) & got) == 8'h00) && (got != 8'hFF)), 32'd1);
        for (int k = 0; k < 20; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            run_req(0, a, b, got, lat, cut);
        end

        // 2: always-mutate with equal parents flips exactly one bit
        for (int k = 0; k < 100; k++) begin
            run_req(1, 8'hAA, 8'hAA, got, lat, cut);
            check("t2_one_flip", 32'($countones(got ^ 8'hAA)), 32'd1);
        end

        // 3: non-power-of-two width, rejection sampling, full cut coverage
        for (int c = 0; c < 8; c++) cut_seen[c] = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            a = 8'($urandom_range(0, 63));
            b = 8'($urandom_range(0, 63));
            run_req(2, a, b, got, lat, cut);
            cut_seen[cut] = 1'b1;
            if (lat < 3) check("t3_latency_min", 32'(lat), 32'd3);
        end
        for (int c = 0; c < 6; c++) begin
            check("t3_cut_covered", 32'(cut_seen[c]), 32'd1);
        end
        check("t3_cut6_absent", 32'(cut_seen[6] | cut_seen[7]), 32'd0);

        // 4: reset during PICK drops the request
        @(negedge clk);
        st[1] = 1'b1;
        pa[1] = 8'h3C;
        pb[1] = 8'hC3;
        @(posedge clk);
        #1;
        st[1] = 1'b0;
        check("t4_busy_in_pick", 32'(busy1), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t4_busy_after_rst", 32'(busy1), 32'd0);
        check("t4_valid_after_rst", 32'(cv1), 32'd0);
        check("t4_child_after_rst", 32'(ch1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            #1;
            if (cv1) stale++;
        end
        check("t4_no_stale_pulse", 32'(stale), 32'd0);
        run_req(1, 8'h0F, 8'hF0, got, lat, cut);

        // 5: start held high gives a pulse every 4 cycles
        @(negedge clk);
        st[0] = 1'b1;
        pa[0] = 8'h5A;
        pb[0] = 8'hA5;
        pulses = 0;
        last = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (cv0) begin
                pulses++;
                if (last < 0) check("t5_first_pulse", 32'(e), 32'd3);
                else check("t5_gap", 32'(e - last), 32'd4);
                last = e;
            end
        end
        @(negedge clk);
        st[0] = 1'b0;
        check("t5_pulse_count", 32'(pulses), 32'd10);
        repeat (2) @(posedge clk);
        #1;
        check("t5_idle", 32'(busy0), 32'd0);

        // 6: same seed gives identical sequences; seed 0 matches seed 1
        for (int k = 0; k < 30; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            run_req(3, a, b, got, lat, cut);
            a = 8'($urandom);
            b = 8'($urandom);
            run_req(4, a, b, got, lat, cut);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case a wait is never satisfied
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
